// File: rtl/snake_link_tx.sv
`default_nettype none
// ============================================================================
// Module   : snake_link_tx
// Brief    : Snake-link transmitter. Encodes seed/direction events as opcode
//            bytes and serializes them as 8N1 UART frames on tx.
// Revision : 1.0 - initial release
// ============================================================================
module snake_link_tx #(
    parameter int CLKS_PER_BIT = 565
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       seed_rdy,
    input  logic [5:0] seed_x,
    input  logic [5:0] seed_y,
    input  logic       send,
    input  logic [2:0] dir,
    output logic       tx,
    output logic       busy,
    output logic       byte_sent
);

    localparam int                  c_BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_ONE  = c_BAUD_W'(1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_START = 2'd1;
    localparam logic [1:0] c_S_DATA  = 2'd2;
    localparam logic [1:0] c_S_STOP  = 2'd3;

    logic [1:0]          r_state,     w_state_n;
    logic [c_BAUD_W-1:0] r_baud,      w_baud_n;
    logic [2:0]          r_bit,       w_bit_n;
    logic [7:0]          r_shift,     w_shift_n;
    logic                r_seed_pend, w_seed_pend_n;
    logic [5:0]          r_px,        w_px_n;
    logic [5:0]          r_py,        w_py_n;
    logic                r_dir_pend,  w_dir_pend_n;
    logic [2:0]          r_pdir,      w_pdir_n;
    logic                r_y_next,    w_y_next_n;
    logic [5:0]          r_y_active,  w_y_active_n;
    logic                r_tx,        w_tx_n;
    logic                r_byte_sent, w_byte_sent_n;
    logic                r_seed_prev;
    logic                r_send_prev;

    logic w_seed_edge;
    logic w_send_edge;
    logic w_bit_end;

    assign w_seed_edge = seed_rdy & ~r_seed_prev;
    assign w_send_edge = send & ~r_send_prev;
    assign w_bit_end   = (r_baud == c_BAUD_LAST);

    always_comb begin
        w_state_n     = r_state;
        w_baud_n      = r_baud;
        w_bit_n       = r_bit;
        w_shift_n     = r_shift;
        w_seed_pend_n = r_seed_pend;
        w_px_n        = r_px;
        w_py_n        = r_py;
        w_dir_pend_n  = r_dir_pend;
        w_pdir_n      = r_pdir;
        w_y_next_n    = r_y_next;
        w_y_active_n  = r_y_active;
        w_tx_n        = 1'b1;
        w_byte_sent_n = 1'b0;

        case (r_state)
            c_S_IDLE: begin
                // Y of a pair goes first so a direction byte can never split X/Y
                if (r_y_next) begin
                    w_shift_n  = {2'b10, r_y_active};
                    w_y_next_n = 1'b0;
                    w_baud_n   = '0;
                    w_state_n  = c_S_START;
                end else if (r_seed_pend) begin
                    w_shift_n     = {2'b01, r_px};
                    w_y_active_n  = r_py;
                    w_y_next_n    = 1'b1;
                    w_seed_pend_n = 1'b0;
                    w_baud_n      = '0;
                    w_state_n     = c_S_START;
                end else if (r_dir_pend) begin
                    w_shift_n    = {5'b00000, r_pdir};
                    w_dir_pend_n = 1'b0;
                    w_baud_n     = '0;
                    w_state_n    = c_S_START;
                end
            end
            c_S_START: begin
                w_tx_n = 1'b0;
                if (w_bit_end) begin
                    w_baud_n  = '0;
                    w_bit_n   = 3'd0;
                    w_state_n = c_S_DATA;
                end else begin
                    w_baud_n = r_baud + c_BAUD_ONE;
                end
            end
            c_S_DATA: begin
                w_tx_n = r_shift[0];
                if (w_bit_end) begin
                    w_baud_n  = '0;
                    w_shift_n = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_n = c_S_STOP;
                    end else begin
                        w_bit_n = r_bit + 3'd1;
                    end
                end else begin
                    w_baud_n = r_baud + c_BAUD_ONE;
                end
            end
            c_S_STOP: begin
                w_tx_n = 1'b1;
                if (w_bit_end) begin
                    w_baud_n      = '0;
                    w_byte_sent_n = 1'b1;
                    w_state_n     = c_S_IDLE;
                end else begin
                    w_baud_n = r_baud + c_BAUD_ONE;
                end
            end
            default: begin
                w_state_n = c_S_IDLE;
                w_baud_n  = '0;
            end
        endcase

        // Capture comes last so a fresh edge wins over a same-cycle clear
        if (w_seed_edge) begin
            w_seed_pend_n = 1'b1;
            w_px_n        = seed_x;
            w_py_n        = seed_y;
        end
        if (w_send_edge) begin
            w_dir_pend_n = 1'b1;
            w_pdir_n     = dir;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_S_IDLE;
            r_baud      <= '0;
            r_bit       <= 3'd0;
            r_shift     <= 8'h00;
            r_seed_pend <= 1'b0;
            r_px        <= 6'd0;
            r_py        <= 6'd0;
            r_dir_pend  <= 1'b0;
            r_pdir      <= 3'd0;
            r_y_next    <= 1'b0;
            r_y_active  <= 6'd0;
            r_tx        <= 1'b1;
            r_byte_sent <= 1'b0;
            r_seed_prev <= 1'b0;
            r_send_prev <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_baud      <= w_baud_n;
            r_bit       <= w_bit_n;
            r_shift     <= w_shift_n;
            r_seed_pend <= w_seed_pend_n;
            r_px        <= w_px_n;
            r_py        <= w_py_n;
            r_dir_pend  <= w_dir_pend_n;
            r_pdir      <= w_pdir_n;
            r_y_next    <= w_y_next_n;
            r_y_active  <= w_y_active_n;
            r_tx        <= w_tx_n;
            r_byte_sent <= w_byte_sent_n;
            r_seed_prev <= seed_rdy;
            r_send_prev <= send;
        end
    end

    assign tx        = r_tx;
    assign byte_sent = r_byte_sent;
    assign busy      = (r_state != c_S_IDLE) | r_seed_pend | r_y_next | r_dir_pend;

endmodule
`default_nettype wire

// File: tb/tb_snake_link_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_snake_link_tx
// Brief    : Self-checking bench for snake_link_tx (vector table, corner
//            sequences and randomized traffic against a frame-level model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_snake_link_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    typedef struct packed {
        logic           seed;
        logic           snd;
        logic [5:0]     x;
        logic [5:0]     y;
        logic [2:0]     d;
        logic [1:0]     n;
        logic [2:0][7:0] b;
    } vec_t;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       seed_rdy = 1'b0;
    logic [5:0] seed_x   = 6'd0;
    logic [5:0] seed_y   = 6'd0;
    logic       send     = 1'b0;
    logic [2:0] dir      = 3'd0;
    logic       tx;
    logic       busy;
    logic       byte_sent;

    int total = 0;
    int bad   = 0;

    logic [7:0] rx_q[$];
    int         sent_cnt = 0;

    snake_link_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .seed_rdy  (seed_rdy),
        .seed_x    (seed_x),
        .seed_y    (seed_y),
        .send      (send),
        .dir       (dir),
        .tx        (tx),
        .busy      (busy),
        .byte_sent (byte_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: requests queue up as pending slots; a frame loaded at edge L
    // appears on the line from edge L+1 for FRAME cycles, and the next load
    // can happen no earlier than edge L+FRAME+1.
    longint     k      = 0;
    longint     m_load = -1000;
    bit         m_seed_p, m_dir_p, m_y_next, m_prev_seed, m_prev_send;
    bit [5:0]   m_px, m_py, m_ya;
    bit [2:0]   m_pdir;
    bit [7:0]   m_byte;
    bit         dec_on  = 1'b0;
    int         dec_cnt = 0;
    logic [7:0] dec_byte;

    always @(posedge clk) begin : b_model
        logic   rst_now;
        longint o;
        int     bi;
        logic   e_tx, e_bs, e_busy;
        rst_now = rst;
        if (rst) begin
            m_seed_p = 0; m_dir_p = 0; m_y_next = 0;
            m_prev_seed = 0; m_prev_send = 0;
            m_load = -1000;
        end else begin
            if (k - m_load > FRAME) begin
                if (m_y_next) begin
                    m_byte = {2'b10, m_ya}; m_y_next = 0; m_load = k;
                end else if (m_seed_p) begin
                    m_byte = {2'b01, m_px}; m_ya = m_py; m_y_next = 1; m_seed_p = 0; m_load = k;
                end else if (m_dir_p) begin
                    m_byte = {5'b00000, m_pdir}; m_dir_p = 0; m_load = k;
                end
            end
            if (seed_rdy && !m_prev_seed) begin
                m_seed_p = 1; m_px = seed_x; m_py = seed_y;
            end
            if (send && !m_prev_send) begin
                m_dir_p = 1; m_pdir = dir;
            end
            m_prev_seed = seed_rdy;
            m_prev_send = send;
        end
        o = k - m_load - 1;
        e_tx = 1'b1;
        if (o >= 0 && o < FRAME) begin
            bi = int'(o / CPB);
            if (bi == 0)      e_tx = 1'b0;
            else if (bi < 9)  e_tx = m_byte[bi-1];
        end
        e_bs   = (o == FRAME - 1);
        e_busy = (k >= m_load && k - m_load < FRAME) || m_seed_p || m_dir_p || m_y_next;
        k++;
        #1;
        chk("tx", tx, e_tx);
        chk("busy", busy, e_busy);
        chk("byte_sent", byte_sent, e_bs);

        // Line decoder: mid-bit sampling of whatever the DUT puts on tx
        if (rst_now) begin
            dec_on = 1'b0;
        end else if (!dec_on) begin
            if (tx === 1'b0) begin
                dec_on  = 1'b1;
                dec_cnt = 0;
            end
        end else begin
            dec_cnt++;
        end
        if (dec_on) begin
            for (int i = 0; i < 8; i++)
                if (dec_cnt == CPB * (i + 1) + CPB / 2) dec_byte[i] = tx;
            if (dec_cnt == 9 * CPB + CPB / 2) begin
                rx_q.push_back(tx === 1'b1 ? dec_byte : 8'hxx);
                dec_on = 1'b0;
            end
        end
        if (byte_sent === 1'b1) sent_cnt++;
    end

    function automatic vec_t mk(input logic s, input logic sn, input logic [5:0] x,
                                input logic [5:0] y, input logic [2:0] d,
                                input logic [1:0] n, input logic [23:0] b);
        vec_t v;
        v.seed = s; v.snd = sn; v.x = x; v.y = y; v.d = d; v.n = n; v.b = b;
        return v;
    endfunction

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1; seed_rdy = 1'b0; send = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        rx_q.delete();
        sent_cnt = 0;
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (busy !== 1'b0 && n < maxc);
        chk({name, "_idle"}, busy, 0);
        @(negedge clk);
    endtask

    task automatic wait_tx_low(input string name, input int maxc);
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (tx !== 1'b0 && n < maxc);
        chk({name, "_txlow"}, tx, 0);
    endtask

    task automatic chk_rx(input string name, input int n, input logic [2:0][7:0] b);
        chk({name, "_count"}, rx_q.size(), n);
        for (int i = 0; i < n && i < rx_q.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), rx_q[i], b[i]);
        chk({name, "_sent"}, sent_cnt, n);
    endtask

    initial begin
        vec_t       vecs[6];
        logic [7:0] exp_b;
        int         n;

        vecs[0] = mk(0, 1, 6'h00, 6'h00, 3'b010, 2'd1, {8'h00, 8'h00, 8'h02});
        vecs[1] = mk(1, 0, 6'h2A, 6'h15, 3'b000, 2'd2, {8'h00, 8'h95, 8'h6A});
        vecs[2] = mk(1, 1, 6'h2A, 6'h15, 3'b101, 2'd3, {8'h05, 8'h95, 8'h6A});
        vecs[3] = mk(1, 0, 6'h3F, 6'h00, 3'b000, 2'd2, {8'h00, 8'h80, 8'h7F});
        vecs[4] = mk(0, 1, 6'h00, 6'h00, 3'b111, 2'd1, {8'h00, 8'h00, 8'h07});
        vecs[5] = mk(1, 1, 6'h00, 6'h3F, 3'b000, 2'd3, {8'h00, 8'hBF, 8'h40});

        // Reset held 5 cycles, then a quiet idle line
        repeat (5) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            chk("idle_tx", tx, 1);
            chk("idle_busy", busy, 0);
            chk("idle_byte_sent", byte_sent, 0);
        end

        // Direction frame: latency and bit-by-bit line shape
        @(negedge clk);
        rx_q.delete(); sent_cnt = 0;
        dir = 3'b010; send = 1'b1;
        @(posedge clk); #1;
        chk("lat_edge_tx", tx, 1);
        chk("lat_edge_busy", busy, 1);
        @(posedge clk); #1;
        chk("lat_load_tx", tx, 1);
        @(posedge clk); #1;
        chk("lat_start_tx", tx, 0);
        exp_b = 8'h02;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1;
            chk($sformatf("dir_bit%0d", i), tx, exp_b[i]);
        end
        repeat (CPB) @(posedge clk);
        #1;
        chk("dir_stop", tx, 1);
        wait_idle("dir", 200);
        chk_rx("dir", 1, {8'h00, 8'h00, 8'h02});
        send = 1'b0;

        // Seed pair: exactly one idle cycle between X and Y frames
        @(negedge clk);
        rx_q.delete(); sent_cnt = 0;
        seed_x = 6'h2A; seed_y = 6'h15; seed_rdy = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (byte_sent !== 1'b1 && n < 200);
        chk("gap_first_sent", byte_sent, 1);
        chk("gap_stop_tx", tx, 1);
        @(posedge clk); #1;
        chk("gap_idle_tx", tx, 1);
        @(posedge clk); #1;
        chk("gap_start_tx", tx, 0);
        wait_idle("pair", 200);
        chk_rx("pair", 2, {8'h00, 8'h95, 8'h6A});
        seed_rdy = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_reset(2);
            @(negedge clk);
            seed_x = vecs[i].x; seed_y = vecs[i].y; dir = vecs[i].d;
            seed_rdy = vecs[i].seed; send = vecs[i].snd;
            wait_idle($sformatf("vec%0d", i), 400);
            chk_rx($sformatf("vec%0d", i), int'(vecs[i].n), vecs[i].b);
            seed_rdy = 1'b0; send = 1'b0;
        end

        // Two direction requests during a frame: only the latest survives
        do_reset(2);
        @(negedge clk); dir = 3'b001; send = 1'b1;
        @(negedge clk); send = 1'b0;
        wait_tx_low("ovr", 50);
        @(negedge clk); dir = 3'b011; send = 1'b1;
        @(negedge clk); send = 1'b0;
        repeat (3) @(negedge clk);
        dir = 3'b100; send = 1'b1;
        @(negedge clk); send = 1'b0;
        wait_idle("ovr", 400);
        chk_rx("ovr", 2, {8'h00, 8'h04, 8'h01});

        // Reset in the middle of data bit 3 aborts the frame cleanly
        do_reset(2);
        @(negedge clk); dir = 3'b010; send = 1'b1;
        @(negedge clk); send = 1'b0;
        wait_tx_low("abort", 50);
        repeat (4 * CPB + 1) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        chk("abort_byte_sent", byte_sent, 0);
        @(negedge clk); rst = 1'b0;
        chk("abort_nosent", sent_cnt, 0);
        chk("abort_norx", rx_q.size(), 0);
        @(negedge clk); dir = 3'b110; send = 1'b1;
        wait_idle("after_abort", 200);
        chk_rx("after_abort", 1, {8'h00, 8'h00, 8'h06});
        send = 1'b0;

        // Randomized traffic, checked cycle by cycle against the model
        do_reset(2);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            seed_x = 6'($urandom);
            seed_y = 6'($urandom);
            dir    = 3'($urandom);
            if ($urandom_range(0, 29) == 0) seed_rdy = ~seed_rdy;
            if ($urandom_range(0, 19) == 0) send = ~send;
            rst = ($urandom_range(0, 799) == 0);
        end
        @(negedge clk);
        rst = 1'b0; seed_rdy = 1'b0; send = 1'b0;
        wait_idle("rand", 1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
